// File: rtl/pulse_sync_arb_if.sv
// ============================================================================
// Module      : pulse_sync_arb_if
// Description : Event-request / issue bundle shared between the requester
//               side (master) and the pulse_sync_arb scheduler (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_sync_arb_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req_s;
   logic [NUM_REQ-1:0] mask;
   logic               ovf_clr;
   logic               event_s;
   logic [ID_W-1:0]    event_id;
   logic               busy;
   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] ovf;
   logic [7:0]         ovf_cnt;

   modport master (
      output req_s, mask, ovf_clr,
      input  event_s, event_id, busy, pending, ovf, ovf_cnt
   );

   modport slave (
      input  req_s, mask, ovf_clr,
      output event_s, event_id, busy, pending, ovf, ovf_cnt
   );
endinterface

`default_nettype wire

// File: rtl/pulse_sync_arb.sv
// ============================================================================
// Module      : pulse_sync_arb
// Description : Shares one pulse-synchronizer channel among NUM_REQ event
//               requesters. Request pulses are captured as pending flags,
//               granted round-robin, and issued as single-cycle event_s
//               pulses separated by at least GAP low cycles. Requests that
//               land on an already-pending requester are flagged in ovf.
//               Optional macro PULSE_SYNC_ARB_OVF_CNT_EN builds the
//               saturating dropped-event counter behind ovf_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_sync_arb #(
   parameter int NUM_REQ = 4,
   parameter int GAP     = 4
) (
   input  wire logic       clk_s,
   input  wire logic       rst_s_n,
   input  wire logic       init_s_n,
   pulse_sync_arb_if.slave bus
);
   localparam int              ID_W    = $clog2(NUM_REQ);
   localparam logic [7:0]      GAP_LD  = 8'(GAP);
   localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GUARD = 2'd2
   } state_t;

   state_t             state;
   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] ovf;
   logic [7:0]         guard;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    event_id;
   logic               event_s;

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] issue_vec;
   logic [NUM_REQ-1:0] ovf_set;
   logic [ID_W-1:0]    winner;
   logic               found;
   logic               issue;

   assign elig  = pending & ~bus.mask;
   assign issue = (guard == 8'd0) && found;

   // Round-robin search over eligible requesters, starting just after the last winner
   always_comb begin
      int              idx;
      logic [ID_W-1:0] cand;
      idx    = 0;
      cand   = '0;
      winner = '0;
      found  = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx  = (int'(ptr) + k) % NUM_REQ;
         cand = ID_W'(idx);
         if (!found && elig[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // One-hot of the requester being issued this edge; a same-edge request re-arms it
   always_comb begin
      issue_vec = '0;
      if (issue) begin
         issue_vec[winner] = 1'b1;
      end
   end

   assign ovf_set = bus.req_s & pending & ~issue_vec;

   // Scheduler FSM with registered event outputs, pending capture and guard counter
   always_ff @(posedge clk_s or negedge rst_s_n) begin
      if (!rst_s_n) begin
         state    <= S_IDLE;
         pending  <= '0;
         ovf      <= '0;
         guard    <= 8'd0;
         ptr      <= PTR_RST;
         event_id <= '0;
         event_s  <= 1'b0;
      end else if (!init_s_n) begin
         state    <= S_IDLE;
         pending  <= '0;
         ovf      <= '0;
         guard    <= 8'd0;
         ptr      <= PTR_RST;
         event_id <= '0;
         event_s  <= 1'b0;
      end else begin
         pending <= bus.req_s | (pending & ~issue_vec);
         // A fresh overflow wins over a simultaneous clear
         ovf     <= ovf_set | (ovf & ~{NUM_REQ{bus.ovf_clr}});

         if (issue) begin
            event_s  <= 1'b1;
            event_id <= winner;
            ptr      <= winner;
            guard    <= GAP_LD;
         end else begin
            event_s <= 1'b0;
            if (guard != 8'd0) begin
               guard <= guard - 8'd1;
            end
         end

         // ISSUE always moves to GUARD because the guard is loaded with GAP >= 1
         case (state)
            S_IDLE:  if (issue) state <= S_ISSUE;
            S_ISSUE: state <= S_GUARD;
            S_GUARD: begin
               if (issue) begin
                  state <= S_ISSUE;
               end else if (guard == 8'd0) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef PULSE_SYNC_ARB_OVF_CNT_EN
   logic [7:0] ovf_cnt;
   logic [4:0] ovf_inc;
   logic [8:0] ovf_sum;

   // Number of requesters dropping an event this cycle
   always_comb begin
      ovf_inc = 5'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ovf_inc = ovf_inc + 5'(ovf_set[i]);
      end
   end

   assign ovf_sum = {1'b0, ovf_cnt} + 9'(ovf_inc);

   // Saturating dropped-event total; a clear still keeps this cycle's increment
   always_ff @(posedge clk_s or negedge rst_s_n) begin
      if (!rst_s_n) begin
         ovf_cnt <= 8'd0;
      end else if (!init_s_n) begin
         ovf_cnt <= 8'd0;
      end else if (bus.ovf_clr) begin
         ovf_cnt <= 8'(ovf_inc);
      end else if (ovf_sum > 9'd255) begin
         ovf_cnt <= 8'd255;
      end else begin
         ovf_cnt <= ovf_sum[7:0];
      end
   end

   assign bus.ovf_cnt = ovf_cnt;
`else
   assign bus.ovf_cnt = 8'd0;
`endif

   assign bus.event_s  = event_s;
   assign bus.event_id = event_id;
   assign bus.busy     = (guard != 8'd0);
   assign bus.pending  = pending;
   assign bus.ovf      = ovf;

endmodule

`default_nettype wire

// File: tb/tb_pulse_sync_arb.sv
// ============================================================================
// Module      : tb_pulse_sync_arb
// Description : Scoreboard bench for pulse_sync_arb (NUM_REQ=4, GAP=4).
//               Stimulus pushes the expected {id, cycle} of every event;
//               a negedge monitor pops and compares each event_s pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_sync_arb;
   localparam int NUM_REQ = 4;
   localparam int GAP     = 4;

`ifdef PULSE_SYNC_ARB_OVF_CNT_EN
   localparam int EXP_CNT_OVF = 1;
`else
   localparam int EXP_CNT_OVF = 0;
`endif

   typedef struct {
      int id;
      int cyc;
   } exp_t;

   logic clk_s    = 1'b0;
   logic rst_s_n  = 1'b0;
   logic init_s_n = 1'b1;
   int   cyc      = 0;
   int   n_pass   = 0;
   int   n_total  = 0;
   logic prev_ev  = 1'b0;
   exp_t exp_q[$];

   pulse_sync_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

   pulse_sync_arb #(
      .NUM_REQ (NUM_REQ),
      .GAP     (GAP)
   ) dut (
      .clk_s    (clk_s),
      .rst_s_n  (rst_s_n),
      .init_s_n (init_s_n),
      .bus      (bus.slave)
   );

   always #5 clk_s = ~clk_s;

   // Cycle index: the value seen at a negedge names that clock cycle
   always @(posedge clk_s) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_s);
   endtask

   // Called right after a negedge: drive one cycle of requests, return at the next negedge
   task automatic pulse(input logic [3:0] r);
      bus.req_s = r;
      @(negedge clk_s);
      bus.req_s = 4'b0000;
   endtask

   task automatic expect_ev(input int id, input int at);
      exp_t e;
      e.id  = id;
      e.cyc = at;
      exp_q.push_back(e);
   endtask

   // Monitor: every event_s pulse is matched against the scoreboard head
   always @(negedge clk_s) begin
      exp_t e;
      if (bus.event_s === 1'b1) begin
         check("event_s back-to-back", 32'(prev_ev), 32'd0);
         check("event expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event_id", 32'(bus.event_id), 32'(e.id));
            check("event cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      prev_ev = bus.event_s;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int nbusy;
      bus.req_s   = 4'b0000;
      bus.mask    = 4'b0000;
      bus.ovf_clr = 1'b0;

      // Reset state
      wait_cyc(3);
      check("rst event_s", 32'(bus.event_s), 32'd0);
      check("rst event_id", 32'(bus.event_id), 32'd0);
      check("rst pending", 32'(bus.pending), 32'd0);
      check("rst ovf", 32'(bus.ovf), 32'd0);
      check("rst ovf_cnt", 32'(bus.ovf_cnt), 32'd0);
      check("rst busy", 32'(bus.busy), 32'd0);
      rst_s_n = 1'b1;
      wait_cyc(2);

      // Single request: event two edges later, busy for GAP cycles
      k = cyc;
      expect_ev(0, k + 2);
      pulse(4'b0001);
      check("t1 pending set", 32'(bus.pending), 32'h1);
      wait_cyc(1);
      check("t1 pending cleared", 32'(bus.pending), 32'h0);
      nbusy = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.busy === 1'b1) nbusy++;
         @(negedge clk_s);
      end
      check("t1 busy cycles", 32'(nbusy), 32'(GAP));

      // Init restores the reset pointer (pointer was 0, so order would be 1,2,3,0 otherwise)
      init_s_n = 1'b0;
      wait_cyc(1);
      init_s_n = 1'b1;
      check("init event_id", 32'(bus.event_id), 32'd0);
      wait_cyc(1);

      // Simultaneous requests: IDs 0..3 spaced GAP+1 apart
      k = cyc;
      for (int i = 0; i < 4; i++) expect_ev(i, k + 2 + i * (GAP + 1));
      pulse(4'b1111);
      wait_cyc(19);
      check("t2 ovf", 32'(bus.ovf), 32'h0);

      // Request during pending: requester 2 re-requests while waiting behind the guard
      k = cyc;
      expect_ev(0, k + 2);
      expect_ev(2, k + 7);
      pulse(4'b0101);
      wait_cyc(2);
      pulse(4'b0100);
      check("t3 ovf set", 32'(bus.ovf), 32'h4);
      check("t3 ovf_cnt", 32'(bus.ovf_cnt), 32'(EXP_CNT_OVF));
      check("t3 pending", 32'(bus.pending), 32'h4);
      wait_cyc(8);
      check("t3 ovf sticky", 32'(bus.ovf), 32'h4);
      bus.ovf_clr = 1'b1;
      wait_cyc(1);
      bus.ovf_clr = 1'b0;
      check("t3 ovf cleared", 32'(bus.ovf), 32'h0);
      check("t3 ovf_cnt cleared", 32'(bus.ovf_cnt), 32'd0);

      // Re-request on the issue edge keeps the bit pending without overflow
      k = cyc;
      expect_ev(1, k + 2);
      expect_ev(1, k + 2 + GAP + 1);
      pulse(4'b0010);
      pulse(4'b0010);
      check("t4 pending kept", 32'(bus.pending), 32'h2);
      check("t4 no ovf", 32'(bus.ovf), 32'h0);
      wait_cyc(10);
      check("t4 pending drained", 32'(bus.pending), 32'h0);

      // Mask defer: requester 1 waits past a guard expiry, then issues once unmasked
      k = cyc;
      bus.mask = 4'b0010;
      expect_ev(0, k + 2);
      pulse(4'b0011);
      wait_cyc(7);
      check("t5 pending deferred", 32'(bus.pending), 32'h2);
      check("t5 idle while masked", 32'(bus.busy), 32'd0);
      bus.mask = 4'b0000;
      expect_ev(1, k + 9);
      wait_cyc(8);
      check("t5 pending drained", 32'(bus.pending), 32'h0);

      // Reset during an event: outputs drop immediately, pointer returns to reset value
      k = cyc;
      expect_ev(3, k + 2);
      pulse(4'b1010);
      wait_cyc(1);
      #1 rst_s_n = 1'b0;
      #1;
      check("t6 event_s dropped", 32'(bus.event_s), 32'd0);
      check("t6 event_id reset", 32'(bus.event_id), 32'd0);
      check("t6 pending reset", 32'(bus.pending), 32'h0);
      check("t6 busy reset", 32'(bus.busy), 32'd0);
      wait_cyc(2);
      rst_s_n = 1'b1;
      wait_cyc(1);
      k = cyc;
      expect_ev(0, k + 2);
      expect_ev(3, k + 2 + GAP + 1);
      pulse(4'b1001);
      wait_cyc(12);

      check("all events seen", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

`default_nettype wire
